// File: rtl/conv_ofm_stream.sv
// conv_ofm_stream: bias/round/saturate conv sums into a banked OFM buffer, stream the frame over AXI4-Stream.
// Optional ReLU after saturation when CONV_OFM_RELU_EN is defined.
module conv_ofm_stream #(
    parameter int LANES  = 3,
    parameter int ACC_W  = 16,
    parameter int DATA_W = 8,
    parameter int OFM_W  = 48,
    parameter int OFM_H  = 48,
    parameter int SHIFT  = 0,
    parameter int AXIS_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        i_bias,
    input  logic                     i_bias_valid,
    input  logic [LANES*ACC_W-1:0]   i_acc,
    input  logic                     i_acc_valid,
    input  logic                     i_send,
    output logic                     m_axis_tvalid,
    output logic [AXIS_W-1:0]        m_axis_tdata,
    output logic [AXIS_W/8-1:0]      m_axis_tstrb,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     o_frame_ready,
    output logic                     o_busy,
    output logic                     o_ovf_err
);
    localparam int PACK  = AXIS_W / DATA_W;
    localparam int WPR   = OFM_W / PACK;
    localparam int DEPTH = WPR * (OFM_H / LANES);
    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LW    = PACK > 1 ? $clog2(PACK) : 1;
    localparam int BW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int RND   = (1 << SHIFT) >> 1;
    localparam logic signed [ACC_W+1:0] PMAX = (ACC_W+2)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W+1:0] NMIN = ~PMAX;
    localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2;

    function automatic logic [DATA_W-1:0] post(input logic signed [ACC_W-1:0] a, input logic signed [DATA_W-1:0] b);
        logic signed [ACC_W+1:0] s;
        logic [DATA_W-1:0] r;
        s = ((ACC_W+2)'(a) + (ACC_W+2)'(b) + (ACC_W+2)'(RND)) >>> SHIFT;
        r = s > PMAX ? PMAX[DATA_W-1:0] : (s < NMIN ? NMIN[DATA_W-1:0] : s[DATA_W-1:0]);
`ifdef CONV_OFM_RELU_EN
        r = r[DATA_W-1] ? '0 : r;
`endif
        return r;
    endfunction

    logic [DATA_W-1:0]       bias_q, bias_d;
    logic [LW-1:0]           wl_q, wl_d, st_lane_q, st_lane_d;
    logic [AW-1:0]           wa_q, wa_d, st_addr_q, st_addr_d;
    logic                    st_v_q, st_v_d, st_last_q, st_last_d;
    logic [LANES*DATA_W-1:0] st_pix_q, st_pix_d;
    logic                    frdy_q, frdy_d, ovf_q, ovf_d;
    logic [1:0]              state_q, state_d, occ_q, occ_d;
    logic [BW-1:0]           rb_q, rb_d;
    logic [AW-1:0]           rbase_q, rbase_d, rc_q, rc_d, ra;
    logic                    wp_q, wp_d, rp_q, rp_d;
    logic [AXIS_W-1:0]       f_data_q [2];
    logic [1:0]              f_last_q;
    logic [AXIS_W-1:0]       mem [LANES][DEPTH];
    logic                    accept, w_last, send_go, rd, r_last, rb_wrap, pop;

    assign m_axis_tvalid = occ_q != 2'd0;
    assign m_axis_tdata  = f_data_q[rp_q];
    assign m_axis_tlast  = m_axis_tvalid && f_last_q[rp_q];
    assign m_axis_tstrb  = '1;
    assign o_frame_ready = frdy_q;
    assign o_busy        = state_q != IDLE;
    assign o_ovf_err     = ovf_q;

    always_comb begin
        // a beat behind the frame-completing write would overwrite the finished frame, so it is dropped too
        accept    = i_acc_valid && !frdy_q && state_q == IDLE && !(st_v_q && st_last_q);
        w_last    = wa_q == AW'(DEPTH - 1) && wl_q == LW'(PACK - 1);
        send_go   = state_q == IDLE && i_send && frdy_q;
        ra        = rbase_q + rc_q;
        rd        = state_q == STREAM && occ_q != 2'd2;
        rb_wrap   = rc_q == AW'(WPR - 1);
        r_last    = rbase_q == AW'(DEPTH - WPR) && rb_q == BW'(LANES - 1) && rb_wrap;
        pop       = m_axis_tvalid && m_axis_tready;
        bias_d    = i_bias_valid ? i_bias : bias_q;
        st_v_d    = accept;
        st_last_d = accept && w_last;
        st_addr_d = wa_q;
        st_lane_d = wl_q;
        st_pix_d  = st_pix_q;
        for (int k = 0; k < LANES; k++)
            st_pix_d[k*DATA_W +: DATA_W] = post(i_acc[k*ACC_W +: ACC_W], bias_q);
        wl_d      = accept ? (wl_q == LW'(PACK - 1) ? '0 : wl_q + 1'b1) : wl_q;
        wa_d      = accept && wl_q == LW'(PACK - 1) ? (w_last ? '0 : wa_q + 1'b1) : wa_q;
        frdy_d    = !send_go && (frdy_q || (st_v_q && st_last_q));
        ovf_d     = ovf_q || (i_acc_valid && !accept);
        state_d   = send_go ? STREAM :
                    (rd && r_last) ? DRAIN :
                    (state_q == DRAIN && pop && m_axis_tlast) ? IDLE : state_q;
        rc_d      = rd ? (rb_wrap ? '0 : rc_q + 1'b1) : rc_q;
        rb_d      = rd && rb_wrap ? (rb_q == BW'(LANES - 1) ? '0 : rb_q + 1'b1) : rb_q;
        rbase_d   = rd && rb_wrap && rb_q == BW'(LANES - 1) ? (r_last ? '0 : rbase_q + AW'(WPR)) : rbase_q;
        occ_d     = occ_q + {1'b0, rd} - {1'b0, pop};
        wp_d      = wp_q ^ rd;
        rp_d      = rp_q ^ pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q    <= '0;
            wl_q      <= '0;
            wa_q      <= '0;
            st_v_q    <= 1'b0;
            st_last_q <= 1'b0;
            st_addr_q <= '0;
            st_lane_q <= '0;
            st_pix_q  <= '0;
            frdy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            rb_q      <= '0;
            rbase_q   <= '0;
            rc_q      <= '0;
            occ_q     <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
        end else begin
            bias_q    <= bias_d;
            wl_q      <= wl_d;
            wa_q      <= wa_d;
            st_v_q    <= st_v_d;
            st_last_q <= st_last_d;
            st_addr_q <= st_addr_d;
            st_lane_q <= st_lane_d;
            st_pix_q  <= st_pix_d;
            frdy_q    <= frdy_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            rb_q      <= rb_d;
            rbase_q   <= rbase_d;
            rc_q      <= rc_d;
            occ_q     <= occ_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (st_v_q)
            for (int k = 0; k < LANES; k++)
                mem[k][st_addr_q][st_lane_q*DATA_W +: DATA_W] <= st_pix_q[k*DATA_W +: DATA_W];
    end

    // the RAM read lands straight in the skid slot, so no separate in-flight stage exists
    always_ff @(posedge clk) begin
        if (rst) begin
            f_data_q <= '{default: '0};
            f_last_q <= '0;
        end else if (rd) begin
            f_data_q[wp_q] <= mem[rb_q][ra];
            f_last_q[wp_q] <= r_last;
        end
    end
endmodule

// File: tb/tb_conv_ofm_stream.sv
// tb_conv_ofm_stream: random and directed frames checked against a pixel-level image model.
module tb_conv_ofm_stream;
    localparam int LANES = 3, ACC_W = 16, DATA_W = 8, OFM_W = 48, OFM_H = 48, AXIS_W = 32;
    localparam int PACK = AXIS_W / DATA_W, WPR = OFM_W / PACK, NB = OFM_H * WPR;
`ifdef CONV_OFM_RELU_EN
    localparam logic [7:0] NEG_SAT = 8'h00;
`else
    localparam logic [7:0] NEG_SAT = 8'h80;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [DATA_W-1:0] i_bias = '0;
    logic i_bias_valid = 1'b0, i_acc_valid = 1'b0, i_send = 1'b0, m_axis_tready = 1'b0;
    logic [LANES*ACC_W-1:0] i_acc = '0;
    logic m_axis_tvalid, m_axis_tlast, o_frame_ready, o_busy, o_ovf_err;
    logic [AXIS_W-1:0] m_axis_tdata;
    logic [AXIS_W/8-1:0] m_axis_tstrb;

    int total = 0, bad = 0, mbias = 0;
    logic [7:0] img [OFM_H][OFM_W];
    logic [31:0] got [NB];

    always #5 clk = ~clk;

    conv_ofm_stream #(.LANES(LANES), .ACC_W(ACC_W), .DATA_W(DATA_W), .OFM_W(OFM_W),
                      .OFM_H(OFM_H), .SHIFT(0), .AXIS_W(AXIS_W)) dut (
        .clk(clk), .rst(rst), .i_bias(i_bias), .i_bias_valid(i_bias_valid),
        .i_acc(i_acc), .i_acc_valid(i_acc_valid), .i_send(i_send),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .o_frame_ready(o_frame_ready), .o_busy(o_busy), .o_ovf_err(o_ovf_err));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int acc, input int bias);
        int s;
        s = acc + bias;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV_OFM_RELU_EN
        if (s < 0) s = 0;
`endif
        return 8'(s);
    endfunction

    function automatic logic [31:0] exp_beat(input int b);
        logic [31:0] v;
        for (int j = 0; j < PACK; j++) v[j*8 +: 8] = img[b / WPR][(b % WPR) * PACK + j];
        return v;
    endfunction

    // kind 0: random sums with directed first two columns and bias changes; kind 1: raster pattern
    task automatic feed_frame(input int kind, input bit probe);
        int d0 [3] = '{100, -3, 200};
        int acc, nb;
        bit bchg;
        for (int s = 0; s < OFM_H / LANES; s++) begin
            for (int c = 0; c < OFM_W; c++) begin
                if (probe && s == 5 && c == 0) begin
                    i_acc_valid = 1'b0;
                    i_bias_valid = 1'b0;
                    i_send = 1'b1;
                    tick;
                    i_send = 1'b0;
                    tick;
                    tick;
                    chk("early_send_tvalid", 32'(m_axis_tvalid), 0);
                    chk("early_send_busy", 32'(o_busy), 0);
                end
                for (int k = 0; k < LANES; k++) begin
                    if (kind == 1) acc = ((s * LANES + k) * OFM_W + c) & 127;
                    else if (s == 0 && c == 0) acc = d0[k];
                    else if (s == 0 && c == 1) acc = -1000;
                    else acc = int'($urandom_range(600)) - 300;
                    img[s * LANES + k][c] = ref_pix(acc, mbias);
                    i_acc[k*ACC_W +: ACC_W] = 16'(acc);
                end
                i_acc_valid = 1'b1;
                bchg = kind == 0 && $urandom_range(15) == 0;
                nb = int'($urandom_range(40)) - 20;
                i_bias = 8'(nb);
                i_bias_valid = bchg;
                tick;
                if (bchg) mbias = nb;
                if (!(s == OFM_H / LANES - 1 && c == OFM_W - 1) && $urandom_range(7) == 0) begin
                    i_acc_valid = 1'b0;
                    i_bias_valid = 1'b0;
                    tick;
                end
            end
        end
        i_acc_valid = 1'b0;
        i_bias_valid = 1'b0;
        chk("frdy_pending", 32'(o_frame_ready), 0);
        i_send = 1'b1;
        tick;
        i_send = 1'b0;
        chk("frdy_set", 32'(o_frame_ready), 1);
        chk("send_on_write_ignored", 32'(o_busy), 0);
    endtask

    task automatic stream_frame(input bit rnd, input int ovf_at, input int rst_at);
        int b, cyc;
        bit stall;
        logic [31:0] pd;
        chk("frdy_before_send", 32'(o_frame_ready), 1);
        m_axis_tready = 1'b0;
        i_send = 1'b1;
        tick;
        i_send = 1'b0;
        chk("lat1_tvalid", 32'(m_axis_tvalid), 0);
        chk("lat1_busy", 32'(o_busy), 1);
        chk("send_clears_frdy", 32'(o_frame_ready), 0);
        tick;
        chk("lat2_tvalid", 32'(m_axis_tvalid), 1);
        b = 0;
        cyc = 0;
        stall = 1'b0;
        pd = '0;
        while (b < NB && cyc < 5000) begin
            if (b == rst_at) begin
                rst = 1'b1;
                m_axis_tready = 1'b0;
                tick;
                rst = 1'b0;
                mbias = 0;
                chk("rst_tvalid", 32'(m_axis_tvalid), 0);
                chk("rst_tlast", 32'(m_axis_tlast), 0);
                chk("rst_busy", 32'(o_busy), 0);
                chk("rst_ovf", 32'(o_ovf_err), 0);
                return;
            end
            m_axis_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
            i_acc_valid = b == ovf_at;
            if (stall) begin
                chk("hold_valid", 32'(m_axis_tvalid), 1);
                chk("hold_data", m_axis_tdata, pd);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got[b] = m_axis_tdata;
                chk("beat_data", m_axis_tdata, exp_beat(b));
                chk("beat_last", 32'(m_axis_tlast), 32'(b == NB - 1));
                b++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            tick;
            cyc++;
        end
        i_acc_valid = 1'b0;
        m_axis_tready = 1'b0;
        chk("beat_count", b, NB);
        chk("busy_after_last", 32'(o_busy), 0);
        chk("no_extra_beat", 32'(m_axis_tvalid), 0);
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_tvalid0", 32'(m_axis_tvalid), 0);
        chk("rst_tlast0", 32'(m_axis_tlast), 0);
        chk("rst_tdata0", m_axis_tdata, 0);
        chk("rst_tstrb0", 32'(m_axis_tstrb), 32'hF);
        chk("rst_frdy0", 32'(o_frame_ready), 0);
        chk("rst_busy0", 32'(o_busy), 0);
        chk("rst_ovf0", 32'(o_ovf_err), 0);
        rst = 1'b0;
        tick;
        i_bias = 8'h05;
        i_bias_valid = 1'b1;
        tick;
        i_bias_valid = 1'b0;
        mbias = 5;
        feed_frame(0, 1'b0);
        stream_frame(1'b0, -1, -1);
        chk("r0c0", 32'(got[0][7:0]), 32'h69);
        chk("r1c0", 32'(got[WPR][7:0]), 32'h02);
        chk("r2c0_sat", 32'(got[2 * WPR][7:0]), 32'h7F);
        chk("r0c1_negsat", 32'(got[0][15:8]), 32'(NEG_SAT));
        chk("r2c1_negsat", 32'(got[2 * WPR][15:8]), 32'(NEG_SAT));
        chk("ovf_clean", 32'(o_ovf_err), 0);
        i_bias = 8'h00;
        i_bias_valid = 1'b1;
        tick;
        i_bias_valid = 1'b0;
        mbias = 0;
        feed_frame(1, 1'b1);
        stream_frame(1'b0, 200, -1);
        chk("pattern_beat0", got[0], 32'h03020100);
        chk("pattern_beat_last", got[NB - 1], 32'h7F7E7D7C);
        chk("ovf_sticky", 32'(o_ovf_err), 1);
        feed_frame(1, 1'b0);
        stream_frame(1'b1, -1, -1);
        chk("rnd_beat0", got[0], 32'h03020100);
        chk("rnd_beat_last", got[NB - 1], 32'h7F7E7D7C);
        feed_frame(0, 1'b0);
        stream_frame(1'b1, -1, 100);
        chk("rst_frdy", 32'(o_frame_ready), 0);
        feed_frame(0, 1'b0);
        stream_frame(1'b1, -1, -1);
        chk("post_rst_ovf", 32'(o_ovf_err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
